// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, requester ids and width helpers.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        ReqIf = 2'd0,
        ReqD  = 2'd1,
        ReqLd = 2'd2
    } req_id_e;

    localparam logic [3:0] BeAll = 4'hF;

    // Bits needed to hold 0..max, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned max);
        return (max < 2) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and stall signals of the arbiter bundled into one interface.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_be;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata;

    logic              cpu_stall;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata, ld_ready, ld_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output cpu_stall
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output ld_req, ld_we, ld_addr, ld_wdata,
        output mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata, ld_ready, ld_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  cpu_stall
    );

endinterface

// File: rtl/mem_arbiter_arb_prio.sv
// Fixed-priority winner selection: loader > data > fetch, with fetch promoted over data when starved.
module mem_arbiter_arb_prio
    import mem_arbiter_pkg::*;
(
    input  logic    if_req_i,
    input  logic    d_req_i,
    input  logic    ld_req_i,
    input  logic    starve_i,
    output req_id_e win_id_o,
    output logic    win_valid_o
);

    always_comb begin
        win_valid_o = if_req_i | d_req_i | ld_req_i;
        win_id_o    = ReqIf;
        if (ld_req_i) begin
            win_id_o = ReqLd;
        end else if (if_req_i && starve_i) begin
            win_id_o = ReqIf;
        end else if (d_req_i) begin
            win_id_o = ReqD;
        end else begin
            win_id_o = ReqIf;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-cycle sequencer sharing one single-ported memory between fetch, data and loader ports.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    localparam int unsigned CntW    = cnt_w(MEM_LAT);
    localparam int unsigned StarveW = cnt_w(STARVE_MAX);
    localparam logic [CntW-1:0]    LatInit   = CntW'(MEM_LAT - 1);
    localparam logic [StarveW-1:0] StarveTop = StarveW'(STARVE_MAX);

    arb_state_e          state_q, state_d;
    req_id_e             id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic                we_q, we_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [StarveW-1:0]  starve_q, starve_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0]   ld_rdata_q, ld_rdata_d;

    req_id_e win_id;
    logic    win_valid;
    logic    done;
    logic    if_ready, d_ready, ld_ready;

    mem_arbiter_arb_prio u_arb_prio (
        .if_req_i    (bus.if_req),
        .d_req_i     (bus.d_req),
        .ld_req_i    (bus.ld_req),
        .starve_i    (starve_q == StarveTop),
        .win_id_o    (win_id),
        .win_valid_o (win_valid)
    );

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        ld_rdata_d = ld_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d = StAccess;
                    id_d    = win_id;
                    cnt_d   = LatInit;
                    unique case (win_id)
                        ReqLd: begin
                            addr_d  = bus.ld_addr;
                            wdata_d = bus.ld_wdata;
                            be_d    = BeAll;
                            we_d    = bus.ld_we;
                        end
                        ReqD: begin
                            addr_d  = bus.d_addr;
                            wdata_d = bus.d_wdata;
                            be_d    = bus.d_we ? bus.d_be : BeAll;
                            we_d    = bus.d_we;
                        end
                        default: begin
                            addr_d  = bus.if_addr;
                            wdata_d = '0;
                            be_d    = BeAll;
                            we_d    = 1'b0;
                        end
                    endcase
                    // Counts lost arbitrations only while fetch is actually waiting.
                    if (win_id == ReqIf) begin
                        starve_d = '0;
                    end else if (bus.if_req && (starve_q != StarveTop)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    if (!we_q) begin
                        unique case (id_q)
                            ReqLd:   ld_rdata_d = bus.mem_rdata;
                            ReqD:    d_rdata_d  = bus.mem_rdata;
                            default: if_rdata_d = bus.mem_rdata;
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            id_q       <= ReqIf;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            ld_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            ld_rdata_q <= ld_rdata_d;
        end
    end

    assign done     = (state_q == StDone);
    assign if_ready = done && (id_q == ReqIf);
    assign d_ready  = done && (id_q == ReqD);
    assign ld_ready = done && (id_q == ReqLd);

    assign bus.if_ready  = if_ready;
    assign bus.d_ready   = d_ready;
    assign bus.ld_ready  = ld_ready;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.ld_rdata  = ld_rdata_q;

    // Enables decode straight from state so an asynchronous reset drops them at once.
    assign bus.mem_en    = (state_q == StAccess);
    assign bus.mem_we    = (state_q == StAccess) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;

    assign bus.cpu_stall = bus.ld_req | (bus.if_req & ~if_ready) | (bus.d_req & ~d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: memory model, per-port expected-data queues and grant-order queue.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MEM_LAT    (2),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    req_id_e     exp_order [$];
    logic [31:0] q_if [$];
    logic [31:0] q_d  [$];
    logic [31:0] q_ld [$];
    logic [31:0] last_rd [3];
    logic [31:0] shadow [256];

    function automatic logic [31:0] pat(input int unsigned i);
        return 32'h5A5A_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    // Memory model, filled with the pattern on the first clock edge.
    logic [31:0] mem [256];
    bit          filled;
    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
            filled <= 1'b1;
        end else if (bus.mem_en && bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end
    assign bus.mem_rdata = bus.mem_en ? mem[bus.mem_addr[9:2]] : 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input req_id_e id);
        case (id)
            ReqIf:   return bus.if_ready;
            ReqD:    return bus.d_ready;
            default: return bus.ld_ready;
        endcase
    endfunction

    task automatic push_exp(input req_id_e id, input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] e;
        logic [7:0]  ix;
        ix = a[9:2];
        if (we) begin
            for (int b = 0; b < 4; b++) if (be[b]) shadow[ix][8*b +: 8] = wd[8*b +: 8];
            e = last_rd[int'(id)];
        end else begin
            e = shadow[ix];
            last_rd[int'(id)] = e;
        end
        case (id)
            ReqIf:   q_if.push_back(e);
            ReqD:    q_d.push_back(e);
            default: q_ld.push_back(e);
        endcase
    endtask

    // Drives one request at the start of a cycle, waits for its ready, returns latency in cycles.
    task automatic req_go(input req_id_e id, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input bit keep,
                          output int lat);
        case (id)
            ReqIf: begin bus.if_addr = a; bus.if_req = 1'b1; end
            ReqD: begin
                bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_be = be; bus.d_req = 1'b1;
            end
            default: begin
                bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = wd; bus.ld_req = 1'b1;
            end
        endcase
        push_exp(id, we, a, wd, (id == ReqD) ? be : 4'hF);
        lat = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rdy(id)) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) check("ready_timeout", {31'b0, rdy(id)}, 32'h1);
        @(posedge clk);
        #1;
        if (!keep) begin
            case (id)
                ReqIf:   bus.if_req = 1'b0;
                ReqD:    bus.d_req  = 1'b0;
                default: bus.ld_req = 1'b0;
            endcase
        end
    endtask

    task automatic monitor();
        logic [2:0]  r;
        req_id_e     got, exp_id;
        forever begin
            @(negedge clk);
            r = {bus.ld_ready, bus.d_ready, bus.if_ready};
            if (rst && (r != 3'b000)) begin
                check("ready_onehot", $countones(r), 32'd1);
                got = r[2] ? ReqLd : (r[1] ? ReqD : ReqIf);
                if (exp_order.size() == 0) begin
                    check("unexpected_ready", {29'b0, r}, 32'h0);
                end else begin
                    exp_id = exp_order.pop_front();
                    check("grant_order", {30'b0, got}, {30'b0, exp_id});
                end
                if (r[0]) begin
                    if (q_if.size() != 0) check("if_rdata", bus.if_rdata, q_if.pop_front());
                    else check("if_extra_ready", {31'b0, bus.if_ready}, 32'h0);
                end
                if (r[1]) begin
                    if (q_d.size() != 0) check("d_rdata", bus.d_rdata, q_d.pop_front());
                    else check("d_extra_ready", {31'b0, bus.d_ready}, 32'h0);
                end
                if (r[2]) begin
                    if (q_ld.size() != 0) check("ld_rdata", bus.ld_rdata, q_ld.pop_front());
                    else check("ld_extra_ready", {31'b0, bus.ld_ready}, 32'h0);
                end
            end
        end
    endtask

    int lat_a, lat_b, lat_c, bad;

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
        for (int i = 0; i < 256; i++) shadow[i] = pat(i);
        for (int i = 0; i < 3; i++) last_rd[i] = '0;
        fork monitor(); join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_readies", {29'b0, bus.ld_ready, bus.d_ready, bus.if_ready}, 32'h0);
        check("rst_mem_en_we", {30'b0, bus.mem_en, bus.mem_we}, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_rdata_or", bus.if_rdata | bus.d_rdata | bus.ld_rdata, 32'h0);
        check("rst_stall", {31'b0, bus.cpu_stall}, 32'h0);
        @(posedge clk); #1 rst = 1'b1;

        // Loader writes the first instruction word
        @(posedge clk); #1;
        exp_order.push_back(ReqLd);
        req_go(ReqLd, 1'b1, 32'h100, 32'h0050_0093, 4'hF, 1'b0, lat_a);
        check("ld_write_lat", lat_a, 32'd3);

        // Single fetch, cycle-by-cycle
        @(posedge clk); #1;
        exp_order.push_back(ReqIf);
        fork
            req_go(ReqIf, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, lat_a);
            begin
                @(negedge clk);
                check("f_c0", {29'b0, bus.cpu_stall, bus.mem_en, bus.if_ready}, 32'b100);
                for (int c = 1; c <= 2; c++) begin
                    @(negedge clk);
                    check("f_access", {29'b0, bus.cpu_stall, bus.mem_en, bus.if_ready}, 32'b110);
                    check("f_addr", bus.mem_addr, 32'h100);
                end
                @(negedge clk);
                check("f_c3", {29'b0, bus.cpu_stall, bus.mem_en, bus.if_ready}, 32'b001);
                check("f_rdata", bus.if_rdata, 32'h0050_0093);
                @(negedge clk);
                check("f_c4_ready", {31'b0, bus.if_ready}, 32'h0);
            end
        join
        check("f_lat", lat_a, 32'd3);

        // Fetch and load together: data first
        @(posedge clk); #1;
        exp_order.push_back(ReqD);
        exp_order.push_back(ReqIf);
        fork
            req_go(ReqD, 1'b0, 32'h200, 32'h0, 4'hF, 1'b0, lat_a);
            req_go(ReqIf, 1'b0, 32'h104, 32'h0, 4'hF, 1'b0, lat_b);
        join
        check("d_first_lat", lat_a, 32'd3);
        check("if_second_lat", lat_b, 32'd7);

        // Partial store, then read it back
        @(posedge clk); #1;
        exp_order.push_back(ReqD);
        fork
            req_go(ReqD, 1'b1, 32'h204, 32'hDEAD_BEEF, 4'b0011, 1'b0, lat_a);
            begin
                @(negedge clk);
                for (int c = 1; c <= 2; c++) begin
                    @(negedge clk);
                    check("st_en_we_be", {26'b0, bus.mem_en, bus.mem_we, bus.mem_be}, 32'b110011);
                    check("st_addr", bus.mem_addr, 32'h204);
                    check("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
                end
            end
        join
        check("st_lat", lat_a, 32'd3);
        @(posedge clk); #1;
        exp_order.push_back(ReqD);
        req_go(ReqD, 1'b0, 32'h204, 32'h0, 4'hF, 1'b0, lat_a);

        // Starvation: data held high, fetch wins after four data grants
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) exp_order.push_back(ReqD);
        exp_order.push_back(ReqIf);
        exp_order.push_back(ReqD);
        exp_order.push_back(ReqD);
        fork
            begin
                for (int i = 0; i < 6; i++)
                    req_go(ReqD, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 4'hF, i != 5, lat_a);
            end
            req_go(ReqIf, 1'b0, 32'h180, 32'h0, 4'hF, 1'b0, lat_b);
        join
        check("starve_if_lat", lat_b, 32'd19);
        check("starve_clear", 32'(dut.starve_q), 32'h0);

        // All three at once: ld, d, if; stall held until fetch completes
        @(posedge clk); #1;
        exp_order.push_back(ReqLd);
        exp_order.push_back(ReqD);
        exp_order.push_back(ReqIf);
        bad = 0;
        fork
            req_go(ReqLd, 1'b0, 32'h040, 32'h0, 4'hF, 1'b0, lat_a);
            req_go(ReqD, 1'b0, 32'h044, 32'h0, 4'hF, 1'b0, lat_b);
            req_go(ReqIf, 1'b0, 32'h048, 32'h0, 4'hF, 1'b0, lat_c);
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (bus.if_ready) begin
                        check("tri_stall_end", {31'b0, bus.cpu_stall}, 32'h0);
                        break;
                    end
                    if (!bus.cpu_stall) bad++;
                end
            end
        join
        check("tri_stall_hold", bad, 32'd0);
        check("tri_ld_lat", lat_a, 32'd3);
        check("tri_d_lat", lat_b, 32'd7);
        check("tri_if_lat", lat_c, 32'd11);

        // Reset in the second access cycle of a store aborts it
        @(posedge clk); #1;
        bus.d_we = 1'b1; bus.d_addr = 32'h208; bus.d_wdata = 32'h1234_5678; bus.d_be = 4'hF;
        bus.d_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        check("abort_pre", {30'b0, bus.mem_en, bus.mem_we}, 32'b11);
        rst = 1'b0;
        #1;
        check("abort_en_we", {30'b0, bus.mem_en, bus.mem_we}, 32'h0);
        check("abort_state", {30'b0, dut.state_q}, {30'b0, StIdle});
        check("abort_d_rdata", bus.d_rdata, 32'h0);
        @(negedge clk);
        check("abort_no_ready", {31'b0, bus.d_ready}, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) last_rd[i] = '0;
        exp_order.push_back(ReqD);
        req_go(ReqD, 1'b1, 32'h208, 32'h1234_5678, 4'hF, 1'b0, lat_a);
        check("regrant_lat", lat_a, 32'd3);
        @(posedge clk); #1;
        exp_order.push_back(ReqD);
        req_go(ReqD, 1'b0, 32'h208, 32'h0, 4'hF, 1'b0, lat_a);

        repeat (3) @(negedge clk);
        check("order_drained", exp_order.size(), 32'd0);
        check("data_drained", q_if.size() + q_d.size() + q_ld.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported unified memory between three requesters: instruction fetch, data load/store, and the program loader/debug port. The block is a multi-cycle access sequencer with fixed priority and fetch anti-starvation. It drives the memory array and returns a stall to the core datapath so that the PC and register file hold while an access is outstanding.

Parameters:
ADDR_W, 32, address width of all ports.
DATA_W, 32, data width of all ports.
MEM_LAT, 2, number of cycles `mem_en` is held per access. Must be at least 1.
STARVE_MAX, 4, number of consecutive lost arbitrations after which fetch beats data.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous reset, active-low.
if_req  in  1  fetch request; held until if_ready.
if_addr  in  ADDR_W  fetch address (PC).
if_ready  out  1  one-cycle completion pulse.
if_rdata  out  DATA_W  instruction, valid when if_ready=1.
d_req  in  1  data request; held until d_ready.
d_we  in  1  1=store, 0=load.
d_addr  in  ADDR_W  data address.
d_wdata  in  DATA_W  store data.
d_be  in  4  byte enables.
d_ready  out  1  one-cycle completion pulse.
d_rdata  out  DATA_W  load data, valid when d_ready=1.
ld_req  in  1  loader request; held until ld_ready.
ld_we  in  1  loader write.
ld_addr  in  ADDR_W  loader address.
ld_wdata  in  DATA_W  loader write data.
ld_ready  out  1  one-cycle completion pulse.
ld_rdata  out  DATA_W  loader read data.
mem_en  out  1  memory access enable.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_be  out  4  memory byte enables; 4'hF for fetch, loader and loads.
mem_rdata  in  DATA_W  memory read data, valid in the last ACCESS cycle.
cpu_stall  out  1  freezes the core datapath.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All ready outputs 0. mem_en=0, mem_we=0. mem_addr, mem_wdata, rdata outputs 0. Starve counter 0.
  - Reset mid-access aborts the access. No ready pulse is produced. mem_we drops immediately.
- FSM: IDLE -> ACCESS -> DONE -> IDLE.
  - IDLE: if any request is present, latch the winner's id, addr, wdata, be and we; load counter = MEM_LAT-1; go to ACCESS.
  - ACCESS: mem_en=1. mem_we = latched we. mem_* driven from latched registers, stable for all MEM_LAT cycles. Counter decrements; at 0, capture mem_rdata into the winner's rdata register and go to DONE.
  - DONE: the winner's ready=1 for exactly one cycle. Go to IDLE. No grant is made in DONE.
- Latency: request present in IDLE at cycle 0 -> ACCESS in cycles 1..MEM_LAT -> ready at cycle MEM_LAT+1. The next grant is possible at cycle MEM_LAT+2.
- Writes also complete with a ready pulse. For a write, rdata registers are not updated.
- Requests are sampled only in IDLE. Request changes during ACCESS or DONE are ignored. A requester deasserts req in the cycle after ready, or keeps it high to request again.
- Priority: ld > d > if.
  - Starve counter increments, saturating at STARVE_MAX, whenever if_req=1 and another requester is granted. It clears when fetch is granted.
  - When counter==STARVE_MAX and if_req=1, fetch beats d but never beats ld.
- cpu_stall (combinational) = ld_req | (if_req & ~if_ready) | (d_req & ~d_ready).
- Non-selected ready and rdata outputs hold their previous rdata values; their ready stays 0.

Decomposition:
- Shared defines.v additions:
  - FSM state encodings `ARB_IDLE`, `ARB_ACCESS`, `ARB_DONE` (2 bits).
  - Requester ids `REQ_IF`, `REQ_D`, `REQ_LD` (2 bits).
- One sub-module, arb_prio: purely combinational. Inputs are the three requests and the starve flag; output is the winner id and a valid flag.

Test Plan:
- MEM_LAT=2, if_req at cycle 0, if_addr=0x100, mem_rdata=0x00500093 -> mem_en=1 in cycles 1-2 with mem_addr=0x100; if_ready=1 only in cycle 3; if_rdata=0x00500093; cpu_stall=1 in cycles 0-2.
- if_req and d_req (load, addr 0x200) both at cycle 0 -> d_ready at cycle 3; fetch granted at cycle 4; if_ready at cycle 7.
- Store d_we=1, d_addr=0x204, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we=1 and mem_be=4'b0011 for 2 cycles; d_ready pulses; d_rdata unchanged.
- d_req held high continuously with if_req high, STARVE_MAX=4 -> exactly 4 data grants, then a fetch grant, counter back to 0.
- ld, d and if requests all at cycle 0 -> grant order ld, d, if; cpu_stall=1 until if_ready.
- rst driven low in cycle 2 of a store -> mem_en=0 and mem_we=0 immediately; no d_ready pulse. After release, state=IDLE and the request is re-granted.
